output_bus_receiver: RTL and testbench
======================================

// Module: output_bus_receiver
// PURPOSE
// Receive end of the pixel output bus. Captures the BUS-pixel words that the output buffer drives
// and reassembles them into complete pixel rows, which are already Gray-decoded. Hands each row
// to downstream logic (frame store / readout checker) over a valid/ack handshake. Tags every row
// with its row index and flags truncated and dropped rows.
// PARAMETERS
// WIDTH  PixelSensorConfig::PIXEL_ARRAY_WIDTH   pixels per row
// BUS    PixelSensorConfig::OUTPUT_BUS_WIDTH    pixels per bus word; WIDTH % BUS == 0 (elaboration $error otherwise)
// BITS   PixelSensorConfig::PIXEL_BITS          bits per pixel, binary
// ROWS   PixelSensorConfig::PIXEL_ARRAY_HEIGHT  rows per frame, >= 2
// PORTS
// CLK           in   1                 single clock, all logic on posedge
// RESET         in   1                 synchronous, active-high
// BUS_VALID     in   1                 bus word present this cycle (transmitter's sending qualifier)
// BUS_DATA      in   BUS*BITS          word; pixel j of word at [j*BITS +: BITS]
// ROW_ACK       in   1                 downstream accepts ROW_OUT
// CLEAR_ERR     in   1                 clears sticky error flags
// ROW_OUT       out  [WIDTH][BITS]     assembled row, stable while ROW_VALID
// ROW_VALID     out  1                 holding register full
// ROW_INDEX     out  $clog2(ROWS)      row number of ROW_OUT
// FRAME_DONE    out  1                 one-cycle pulse when row ROWS-1 is acked
// ERR_TRUNC     out  1                 sticky: BUS_VALID dropped mid-row
// ERR_OVERFLOW  out  1                 sticky: completed row dropped, holding full
// BEHAVIOUR
// - Reset: all outputs 0. Internal word counter and row counter are 0. State is IDLE.
//   RESET mid-row discards the partial row. RESET overrides all other inputs.
// - Word order: k-th word of a row (k = 0..WIDTH/BUS-1) carries pixels k*BUS .. k*BUS+BUS-1.
// - FSM IDLE: BUS_VALID=1 captures word 0 and moves to RECV (counter=1). A single-word row
//   (WIDTH==BUS) completes immediately.
// - FSM RECV: each BUS_VALID=1 cycle captures word[counter] and increments counter.
//   Capturing the last word completes the row; the counter wraps to 0 and the FSM returns to IDLE.
//   Back-to-back rows with no gap in BUS_VALID are legal. The next word starts a new row.
// - Truncation: BUS_VALID=0 in RECV sets ERR_TRUNC, discards the partial row, returns to IDLE
//   (counter=0). The row counter does not advance.
// - Completion, on the edge capturing the last word:
//   . holding empty, or ROW_VALID & ROW_ACK in the same cycle: holding <= row,
//     ROW_INDEX <= row counter, ROW_VALID=1 from the next cycle. Latency is 1 cycle after the last word.
//   . holding full and not acked: row dropped, ERR_OVERFLOW set, ROW_OUT unchanged.
//   . the row counter advances in both cases (dropped rows keep their slot) and wraps ROWS-1 -> 0.
// - Handshake: ROW_VALID holds until sampled with ROW_ACK=1. ROW_ACK while ROW_VALID=0 is ignored.
//   Ack without a concurrent completion clears ROW_VALID next cycle.
//   Simultaneous ack and completion keep ROW_VALID=1 with new data and no bubble.
// - FRAME_DONE: pulses in the cycle after ROW_VALID & ROW_ACK with ROW_INDEX==ROWS-1.
// - CLEAR_ERR clears both sticky flags. A new error in the same cycle wins (flag stays 1).
// STRUCTURE
// - PixelSensorConfig adds PIXEL_ARRAY_HEIGHT, typedef pixel_t (logic [PIXEL_BITS-1:0]) and
//   typedef pixel_row_t (pixel_t [PIXEL_ARRAY_WIDTH-1:0]).
// - Sub-module row_assembler holds the word counter, the assembly register and the IDLE/RECV FSM.
//   Its outputs: row, row_done pulse, trunc pulse.
// - Top level holds the holding register, the valid/ack handshake, the row counter and the error flags.
// TESTING (config WIDTH=8, BUS=2, BITS=10, ROWS=4)
// 1. Reset, then 4 words 0x001_000, 0x003_002, 0x005_004, 0x007_006 (upper pixel first in hex),
//    ack held 1 -> ROW_OUT[i]=i, ROW_VALID 1 cycle later, ROW_INDEX=0.
// 2. 4 rows back-to-back with BUS_VALID=1 for 16 cycles, ack=1 -> ROW_INDEX 0,1,2,3,
//    FRAME_DONE once after row 3, ERR_* stay 0.
// 3. Ack=0, send 2 rows -> row 0 held, row 1 dropped, ERR_OVERFLOW=1. After ack, the next row
//    shows ROW_INDEX=2.
// 4. BUS_VALID low after 2 words -> ERR_TRUNC=1, no ROW_VALID. The following full row
//    has ROW_INDEX=0. CLEAR_ERR -> flag 0.
// 5. Ack asserted on the exact completion edge of the next row -> ROW_VALID stays 1,
//    ROW_OUT updates, no overflow.
// 6. RESET asserted after 3 words and while ROW_VALID=1 -> all outputs 0 next cycle.
//    A fresh row is received correctly.

Source files
------------

// File: rtl/output_bus_receiver_pkg.sv
// Pixel sensor configuration shared by the output bus receive path.
// Array geometry, pixel types and receive FSM states.
package PixelSensorConfig;

  localparam int PIXEL_ARRAY_WIDTH  = 8;
  localparam int OUTPUT_BUS_WIDTH   = 2;
  localparam int PIXEL_BITS         = 10;
  localparam int PIXEL_ARRAY_HEIGHT = 4;

  typedef logic [PIXEL_BITS-1:0] pixel_t;
  typedef pixel_t [PIXEL_ARRAY_WIDTH-1:0] pixel_row_t;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

endpackage

// File: rtl/output_bus_receiver_if.sv
// Pixel output bus: one word of BUS pixels per valid cycle.
// The output buffer is master, the receiver is slave.
interface output_bus_receiver_if
  import PixelSensorConfig::*;
#(
  parameter int BUS  = OUTPUT_BUS_WIDTH,
  parameter int BITS = PIXEL_BITS
) ();

  logic                BUS_VALID;
  logic [BUS*BITS-1:0] BUS_DATA;

  modport master (
    output BUS_VALID,
    output BUS_DATA
  );

  modport slave (
    input BUS_VALID,
    input BUS_DATA
  );

endinterface

// File: rtl/output_bus_receiver_row_assembler.sv
// Collects WIDTH/BUS bus words into one row.
// row is valid together with the row_done pulse.
module row_assembler
  import PixelSensorConfig::*;
#(
  parameter int WIDTH = PIXEL_ARRAY_WIDTH,
  parameter int BUS   = OUTPUT_BUS_WIDTH,
  parameter int BITS  = PIXEL_BITS
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        bus_valid,
  input  logic [BUS*BITS-1:0]         bus_data,
  output logic [WIDTH-1:0][BITS-1:0]  row,
  output logic                        row_done,
  output logic                        trunc
);

  localparam int WORDS = WIDTH / BUS;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  rx_state_t                   state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [WIDTH-1:0][BITS-1:0]  asm_q, asm_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  // row merges the word on the bus so completion needs no extra cycle
  always_comb begin
    row = asm_q;
    for (int k = 0; k < WORDS; k++) begin
      if (cnt_q == CW'(k)) begin
        for (int j = 0; j < BUS; j++) begin
          row[k*BUS+j] = bus_data[j*BITS +: BITS];
        end
      end
    end
    asm_d = bus_valid ? row : asm_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_done = 1'b0;
    trunc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus_valid) begin
          if (cnt_q == LAST) begin
            row_done = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (bus_valid) begin
          if (cnt_q == LAST) begin
            row_done = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          trunc   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/output_bus_receiver.sv
// Receive end of the pixel output bus: row holding register,
// valid/ack handshake, row numbering and sticky error flags.
module output_bus_receiver
  import PixelSensorConfig::*;
#(
  parameter int WIDTH = PIXEL_ARRAY_WIDTH,
  parameter int BUS   = OUTPUT_BUS_WIDTH,
  parameter int BITS  = PIXEL_BITS,
  parameter int ROWS  = PIXEL_ARRAY_HEIGHT
) (
  input  logic                        CLK,
  input  logic                        RESET,
  output_bus_receiver_if.slave        bus,
  input  logic                        ROW_ACK,
  input  logic                        CLEAR_ERR,
  output logic [WIDTH-1:0][BITS-1:0]  ROW_OUT,
  output logic                        ROW_VALID,
  output logic [$clog2(ROWS)-1:0]     ROW_INDEX,
  output logic                        FRAME_DONE,
  output logic                        ERR_TRUNC,
  output logic                        ERR_OVERFLOW
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  if (WIDTH % BUS != 0) begin : g_bad_bus
    $error("WIDTH must be a multiple of BUS");
  end
  if (ROWS < 2) begin : g_bad_rows
    $error("ROWS must be at least 2");
  end

  logic [WIDTH-1:0][BITS-1:0] row;
  logic                       row_done;
  logic                       trunc;
  logic [RW-1:0]              row_cnt;
  logic                       ack;
  logic                       load;
  logic                       ovf;

  row_assembler #(
    .WIDTH (WIDTH),
    .BUS   (BUS),
    .BITS  (BITS)
  ) u_asm (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus_valid (bus.BUS_VALID),
    .bus_data  (bus.BUS_DATA),
    .row       (row),
    .row_done  (row_done),
    .trunc     (trunc)
  );

  assign ack  = ROW_VALID & ROW_ACK;
  assign load = row_done & (~ROW_VALID | ROW_ACK);
  assign ovf  = row_done & ROW_VALID & ~ROW_ACK;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ROW_OUT      <= '0;
      ROW_VALID    <= 1'b0;
      ROW_INDEX    <= '0;
      FRAME_DONE   <= 1'b0;
      ERR_TRUNC    <= 1'b0;
      ERR_OVERFLOW <= 1'b0;
      row_cnt      <= '0;
    end else begin
      if (load) begin
        ROW_OUT   <= row;
        ROW_INDEX <= row_cnt;
        ROW_VALID <= 1'b1;
      end else if (ack) begin
        ROW_VALID <= 1'b0;
      end
      // dropped rows still consume their row number
      if (row_done) begin
        row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
      end
      FRAME_DONE   <= ack & (ROW_INDEX == LAST_ROW);
      ERR_TRUNC    <= trunc | (ERR_TRUNC & ~CLEAR_ERR);
      ERR_OVERFLOW <= ovf | (ERR_OVERFLOW & ~CLEAR_ERR);
    end
  end

endmodule

// File: tb/tb_output_bus_receiver.sv
// Directed bench for output_bus_receiver.
// Config WIDTH=8, BUS=2, BITS=10, ROWS=4.
module tb_output_bus_receiver;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             ROW_ACK;
  logic             CLEAR_ERR;
  logic [7:0][9:0]  ROW_OUT;
  logic             ROW_VALID;
  logic [1:0]       ROW_INDEX;
  logic             FRAME_DONE;
  logic             ERR_TRUNC;
  logic             ERR_OVERFLOW;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;

  output_bus_receiver_if #(.BUS(2), .BITS(10)) bus ();

  output_bus_receiver dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .bus          (bus),
    .ROW_ACK      (ROW_ACK),
    .CLEAR_ERR    (CLEAR_ERR),
    .ROW_OUT      (ROW_OUT),
    .ROW_VALID    (ROW_VALID),
    .ROW_INDEX    (ROW_INDEX),
    .FRAME_DONE   (FRAME_DONE),
    .ERR_TRUNC    (ERR_TRUNC),
    .ERR_OVERFLOW (ERR_OVERFLOW)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (FRAME_DONE) fd_cnt++;
  end

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [19:0] word(input int base, input int k);
    logic [9:0] lo, hi;
    lo = 10'(base + 2*k);
    hi = 10'(base + 2*k + 1);
    return {hi, lo};
  endfunction

  function automatic logic [127:0] exp_row(input int base);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*10 +: 10] = 10'(base + i);
    return r;
  endfunction

  task automatic send_word(input int base, input int k);
    bus.BUS_VALID = 1'b1;
    bus.BUS_DATA  = word(base, k);
    tick();
  endtask

  task automatic send_words(input int base, input int n);
    for (int k = 0; k < n; k++) send_word(base, k);
  endtask

  task automatic do_reset();
    RESET         = 1'b1;
    bus.BUS_VALID = 1'b0;
    bus.BUS_DATA  = '0;
    ROW_ACK       = 1'b0;
    CLEAR_ERR     = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fd0;
    do_reset();
    check("rst_valid", 128'(ROW_VALID), 128'(0));
    check("rst_out", 128'(ROW_OUT), 128'(0));
    check("rst_errs", 128'({ERR_TRUNC, ERR_OVERFLOW, FRAME_DONE}), 128'(0));

    // 1: single row, pixel i == i
    ROW_ACK = 1'b1;
    send_words(0, 3);
    check("t1_lat", 128'(ROW_VALID), 128'(0));
    send_word(0, 3);
    bus.BUS_VALID = 1'b0;
    check("t1_valid", 128'(ROW_VALID), 128'(1));
    check("t1_out", 128'(ROW_OUT), exp_row(0));
    check("t1_idx", 128'(ROW_INDEX), 128'(0));
    tick();
    check("t1_acked", 128'(ROW_VALID), 128'(0));

    // 2: four rows back-to-back, frame done, wrap
    do_reset();
    ROW_ACK = 1'b1;
    fd0 = fd_cnt;
    for (int r = 0; r < 4; r++) begin
      send_words(r*8, 4);
      check("t2_valid", 128'(ROW_VALID), 128'(1));
      check("t2_idx", 128'(ROW_INDEX), 128'(r));
      check("t2_out", 128'(ROW_OUT), exp_row(r*8));
    end
    bus.BUS_VALID = 1'b0;
    check("t2_fd_early", 128'(FRAME_DONE), 128'(0));
    tick();
    check("t2_fd", 128'(FRAME_DONE), 128'(1));
    tick();
    check("t2_fd_pulse", 128'(FRAME_DONE), 128'(0));
    check("t2_fd_once", 128'(fd_cnt - fd0), 128'(1));
    check("t2_errs", 128'({ERR_TRUNC, ERR_OVERFLOW}), 128'(0));
    send_words(40, 4);
    bus.BUS_VALID = 1'b0;
    check("t2_wrap", 128'(ROW_INDEX), 128'(0));

    // 3: overflow while holding full
    do_reset();
    send_words(16, 4);
    check("t3_idx0", 128'(ROW_INDEX), 128'(0));
    send_words(32, 4);
    bus.BUS_VALID = 1'b0;
    check("t3_ovf", 128'(ERR_OVERFLOW), 128'(1));
    check("t3_held", 128'(ROW_OUT), exp_row(16));
    check("t3_held_idx", 128'(ROW_INDEX), 128'(0));
    ROW_ACK = 1'b1;
    tick();
    check("t3_ack", 128'(ROW_VALID), 128'(0));
    send_words(48, 4);
    bus.BUS_VALID = 1'b0;
    check("t3_idx2", 128'(ROW_INDEX), 128'(2));
    check("t3_out", 128'(ROW_OUT), exp_row(48));

    // 4: truncation, then clear
    do_reset();
    ROW_ACK = 1'b1;
    send_words(200, 2);
    bus.BUS_VALID = 1'b0;
    tick();
    check("t4_trunc", 128'(ERR_TRUNC), 128'(1));
    check("t4_novalid", 128'(ROW_VALID), 128'(0));
    send_words(64, 4);
    bus.BUS_VALID = 1'b0;
    check("t4_idx", 128'(ROW_INDEX), 128'(0));
    check("t4_out", 128'(ROW_OUT), exp_row(64));
    CLEAR_ERR = 1'b1;
    tick();
    CLEAR_ERR = 1'b0;
    check("t4_clear", 128'(ERR_TRUNC), 128'(0));

    // 5: ack on the completion edge
    ROW_ACK = 1'b0;
    send_words(80, 4);
    check("t5_idx1", 128'(ROW_INDEX), 128'(1));
    send_words(96, 3);
    ROW_ACK = 1'b1;
    send_word(96, 3);
    ROW_ACK = 1'b0;
    check("t5_valid", 128'(ROW_VALID), 128'(1));
    check("t5_out", 128'(ROW_OUT), exp_row(96));
    check("t5_idx2", 128'(ROW_INDEX), 128'(2));
    check("t5_noovf", 128'(ERR_OVERFLOW), 128'(0));

    // 6: reset mid-row while holding full
    send_words(112, 3);
    RESET         = 1'b1;
    bus.BUS_VALID = 1'b0;
    tick();
    check("t6_valid", 128'(ROW_VALID), 128'(0));
    check("t6_out", 128'(ROW_OUT), 128'(0));
    check("t6_idx", 128'(ROW_INDEX), 128'(0));
    RESET = 1'b0;
    send_words(120, 4);
    bus.BUS_VALID = 1'b0;
    check("t6_fresh", 128'(ROW_OUT), exp_row(120));
    check("t6_fidx", 128'(ROW_INDEX), 128'(0));
    check("t6_errs", 128'({ERR_TRUNC, ERR_OVERFLOW}), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
